// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

  // Default halfword address width of the attached memory.
  localparam int DEF_ADDR_W = 12;

  // Access size carried on ls_size.
  localparam logic SIZE_HALF = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Direction carried on ls_we.
  localparam logic WE_LOAD  = 1'b0;
  localparam logic WE_STORE = 1'b1;

  // IDLE, IF_RSP and LS_RSP are the arbitration points.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_ACC = 3'd1,
    IF_RSP = 3'd2,
    LS_LO  = 3'd3,
    LS_HI  = 3'd4,
    LS_RSP = 3'd5
  } state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port halfword memory between instruction fetch and
// load/store. Fair alternation on contention, Moore-style memory outputs.
module memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [15:0]       if_rdata,
  output logic              stall_fetch,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic              ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic              stall_ls,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              size_q;
  logic [31:0]       wdata_q;
  logic [15:0]       lo_q;
  logic              last_ls_q;   // 1: load/store was granted most recently

  logic arb_point;
  logic grant_ls;
  logic grant_if;

  // Arbitration decision: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    arb_point = (state == IDLE) || (state == IF_RSP) || (state == LS_RSP);
    grant_ls  = arb_point && ls_req && (!if_req || !last_ls_q);
    grant_if  = arb_point && if_req && !grant_ls;
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Transaction latches, low-halfword capture and fairness history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      we_q      <= WE_LOAD;
      size_q    <= SIZE_HALF;
      wdata_q   <= '0;
      lo_q      <= '0;
      last_ls_q <= 1'b0;
    end else begin
      if (grant_ls) begin
        addr_q    <= ls_addr;
        we_q      <= ls_we;
        size_q    <= ls_size;
        wdata_q   <= ls_wdata;
        last_ls_q <= 1'b1;
      end else if (grant_if) begin
        addr_q    <= if_addr;
        we_q      <= WE_LOAD;
        size_q    <= SIZE_HALF;
        last_ls_q <= 1'b0;
      end
      // Read data of the LS_LO access arrives during LS_HI.
      if (state == LS_HI) lo_q <= mem_rdata;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nx  = state;
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    if_rdata  = '0;
    ls_done   = 1'b0;
    ls_rdata  = '0;

    unique case (state)
      IDLE, IF_RSP, LS_RSP: begin
        if (grant_ls)      state_nx = LS_LO;
        else if (grant_if) state_nx = IF_ACC;
        else               state_nx = IDLE;

        if (state == IF_RSP) begin
          if_valid = 1'b1;
          if_rdata = mem_rdata;
        end
        if (state == LS_RSP) begin
          ls_done = 1'b1;
          if (we_q == WE_LOAD) begin
            if (size_q == SIZE_WORD) ls_rdata = {mem_rdata, lo_q};
            else                     ls_rdata = {16'h0000, mem_rdata};
          end
        end
      end

      IF_ACC: begin
        state_nx = IF_RSP;
        mem_re   = 1'b1;
        mem_addr = addr_q;
      end

      LS_LO: begin
        state_nx = (size_q == SIZE_WORD) ? LS_HI : LS_RSP;
        mem_addr = addr_q;
        if (we_q == WE_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q[15:0];
        end else begin
          mem_re = 1'b1;
        end
      end

      LS_HI: begin
        state_nx = LS_RSP;
        mem_addr = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
        if (we_q == WE_STORE) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q[31:16];
        end else begin
          mem_re = 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Stalls follow the request/completion handshake and are held low in reset.
  assign stall_fetch = !reset && if_req && !if_valid;
  assign stall_ls    = !reset && ls_req && !ls_done;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a behavioural
// single-port memory (read data one cycle after mem_re).
module tb_memory_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = DEF_ADDR_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_valid;
  logic [15:0]   if_rdata;
  logic          stall_fetch;
  logic          ls_req;
  logic          ls_we;
  logic          ls_size;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic          ls_done;
  logic [31:0]   ls_rdata;
  logic          stall_ls;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;

  logic [15:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
    .if_rdata(if_rdata), .stall_fetch(stall_fetch),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .stall_ls(stall_ls),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample just after the edge; re/we exclusivity every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("re_we_excl", {31'd0, mem_re & mem_we}, 32'd0);
  endtask

  task automatic check_quiet_mem(input string tag);
    check({tag, "_re"},   {31'd0, mem_re}, 32'd0);
    check({tag, "_we"},   {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, {20'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'h1C00;
    mem[12'hFFF] = 16'h5678;
    mem[12'h000] = 16'h1234;

    reset    = 1'b1;
    if_req   = 1'b1;   // request during reset must not raise a stall
    if_addr  = 12'h010;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_size  = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    tick();
    tick();

    // ---- reset state ----
    check("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
    check("rst_ls_done",  {31'd0, ls_done}, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_stall_f",  {31'd0, stall_fetch}, 32'd0);
    check("rst_stall_ls", {31'd0, stall_ls}, 32'd0);
    check("rst_wdata",    {16'd0, mem_wdata}, 32'd0);
    check_quiet_mem("rst");

    // ---- fetch only: arbitration cycle 0, mem_re cycle 1, if_valid cycle 2 ----
    reset = 1'b0;
    #1;
    check("f_stall0", {31'd0, stall_fetch}, 32'd1);
    tick();
    check("f_re",     {31'd0, mem_re}, 32'd1);
    check("f_addr",   {20'd0, mem_addr}, 32'h010);
    check("f_valid1", {31'd0, if_valid}, 32'd0);
    check("f_stall1", {31'd0, stall_fetch}, 32'd1);
    tick();
    check("f_valid",  {31'd0, if_valid}, 32'd1);
    check("f_rdata",  {16'd0, if_rdata}, 32'h1C00);
    check("f_stall2", {31'd0, stall_fetch}, 32'd0);
    check_quiet_mem("f_rsp");
    if_req = 1'b0;
    tick();
    check("f_idle_valid", {31'd0, if_valid}, 32'd0);
    check("f_idle_rdata", {16'd0, if_rdata}, 32'd0);

    // ---- word store 0xDEADBEEF at 0x020 ----
    ls_req = 1'b1; ls_we = WE_STORE; ls_size = SIZE_WORD;
    ls_addr = 12'h020; ls_wdata = 32'hDEADBEEF;
    tick();
    check("ws_lo_we",    {31'd0, mem_we}, 32'd1);
    check("ws_lo_re",    {31'd0, mem_re}, 32'd0);
    check("ws_lo_addr",  {20'd0, mem_addr}, 32'h020);
    check("ws_lo_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    check("ws_stall",    {31'd0, stall_ls}, 32'd1);
    tick();
    check("ws_hi_we",    {31'd0, mem_we}, 32'd1);
    check("ws_hi_addr",  {20'd0, mem_addr}, 32'h021);
    check("ws_hi_wdata", {16'd0, mem_wdata}, 32'hDEAD);
    tick();
    check("ws_done",     {31'd0, ls_done}, 32'd1);
    check("ws_rdata",    ls_rdata, 32'd0);
    check("ws_stall_rsp",{31'd0, stall_ls}, 32'd0);
    check_quiet_mem("ws_rsp");
    ls_req = 1'b0;
    tick();
    check("ws_idle_done", {31'd0, ls_done}, 32'd0);
    check("ws_mem_lo",    {16'd0, mem[12'h020]}, 32'hBEEF);
    check("ws_mem_hi",    {16'd0, mem[12'h021]}, 32'hDEAD);

    // ---- word load at 0xFFF wraps to 0x000 ----
    ls_req = 1'b1; ls_we = WE_LOAD; ls_size = SIZE_WORD; ls_addr = 12'hFFF;
    tick();
    check("wl_lo_re",   {31'd0, mem_re}, 32'd1);
    check("wl_lo_addr", {20'd0, mem_addr}, 32'hFFF);
    tick();
    check("wl_hi_re",   {31'd0, mem_re}, 32'd1);
    check("wl_hi_addr", {20'd0, mem_addr}, 32'h000);
    tick();
    check("wl_done",    {31'd0, ls_done}, 32'd1);
    check("wl_rdata",   ls_rdata, 32'h12345678);
    ls_req = 1'b0;
    tick();
    check("wl_idle_rdata", ls_rdata, 32'd0);

    // ---- halfword load at 0x020, then halfword store at 0x040 ----
    ls_req = 1'b1; ls_we = WE_LOAD; ls_size = SIZE_HALF; ls_addr = 12'h020;
    tick();
    check("hl_re", {31'd0, mem_re}, 32'd1);
    tick();
    check("hl_done",  {31'd0, ls_done}, 32'd1);
    check("hl_rdata", ls_rdata, 32'h0000BEEF);
    ls_we = WE_STORE; ls_addr = 12'h040; ls_wdata = 32'h5555AAAA;
    tick();
    check("hs_we",    {31'd0, mem_we}, 32'd1);
    check("hs_wdata", {16'd0, mem_wdata}, 32'hAAAA);
    tick();
    check("hs_done",  {31'd0, ls_done}, 32'd1);
    check("hs_rdata", ls_rdata, 32'd0);
    ls_req = 1'b0;
    tick();
    check("hs_mem",     {16'd0, mem[12'h040]}, 32'hAAAA);
    check("hs_mem_nxt", {16'd0, mem[12'h041]}, 32'h0000);

    // ---- contention after fresh reset: ls first, then alternate ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if_req = 1'b1; if_addr = 12'h010;
    ls_req = 1'b1; ls_we = WE_LOAD; ls_size = SIZE_HALF; ls_addr = 12'h020;
    for (int r = 0; r < 2; r++) begin
      tick();
      check("alt_ls_addr",  {20'd0, mem_addr}, 32'h020);
      check("alt_ls_re",    {31'd0, mem_re}, 32'd1);
      check("alt_f_stall",  {31'd0, stall_fetch}, 32'd1);
      tick();
      check("alt_ls_done",  {31'd0, ls_done}, 32'd1);
      check("alt_ls_rdata", ls_rdata, 32'h0000BEEF);
      check("alt_if_quiet", {31'd0, if_valid}, 32'd0);
      tick();
      check("alt_f_addr",   {20'd0, mem_addr}, 32'h010);
      check("alt_f_re",     {31'd0, mem_re}, 32'd1);
      check("alt_ls_stall", {31'd0, stall_ls}, 32'd1);
      tick();
      check("alt_f_valid",  {31'd0, if_valid}, 32'd1);
      check("alt_f_rdata",  {16'd0, if_rdata}, 32'h1C00);
      check("alt_ls_quiet", {31'd0, ls_done}, 32'd0);
    end
    if_req = 1'b0; ls_req = 1'b0;
    tick();
    check_quiet_mem("alt_idle");
    check("alt_idle_valid", {31'd0, if_valid}, 32'd0);

    // ---- reset during LS_LO of a word store aborts it ----
    ls_req = 1'b1; ls_we = WE_STORE; ls_size = SIZE_WORD;
    ls_addr = 12'h030; ls_wdata = 32'hCAFEF00D;
    tick();
    check("ab_lo_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check("ab_we_now", {31'd0, mem_we}, 32'd0);
    check("ab_done_now", {31'd0, ls_done}, 32'd0);
    ls_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ab_no_done", {31'd0, ls_done}, 32'd0);
      check("ab_no_we",   {31'd0, mem_we}, 32'd0);
    end
    check("ab_mem_lo", {16'd0, mem[12'h030]}, 32'h0000);
    check("ab_mem_hi", {16'd0, mem[12'h031]}, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
